// File: rtl/pipeline_hazard_ctrl.sv
// Hazard and flush controller for the five-stage pipeline.
// Load-use stalls, memory freeze, epoch-based squash, perf and watchdog.
module pipeline_hazard_ctrl #(
    parameter int MEM_TIMEOUT = 255,
    parameter int CNT_W       = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             dec_valid,
    input  logic             dec_epoch,
    input  logic [3:0]       dec_rn,
    input  logic [3:0]       dec_rm,
    input  logic [3:0]       dec_rs,
    input  logic [2:0]       dec_src_used,
    input  logic             ex_valid,
    input  logic             ex_is_load,
    input  logic [3:0]       ex_rd,
    input  logic             br_taken,
    input  logic             br_epoch,
    input  logic             mem_busy,
    input  logic             perf_clear,
    output logic             stall_fd,
    output logic             stall_ex,
    output logic             bubble_ex,
    output logic             redirect,
    output logic             epoch,
    output logic [1:0]       state,
    output logic [CNT_W-1:0] stall_cnt,
    output logic             mem_timeout
);

    localparam logic [1:0] S_RUN   = 2'd0;
    localparam logic [1:0] S_LU    = 2'd1;
    localparam logic [1:0] S_MEM   = 2'd2;
    localparam logic [1:0] S_FLUSH = 2'd3;

    localparam int BW = $clog2(MEM_TIMEOUT + 1);

    logic             r_epoch;
    logic [1:0]       r_state;
    logic [CNT_W-1:0] r_stall_cnt;
    logic [BW-1:0]    r_busy_cnt;
    logic             r_timeout;

    logic          w_live_dec;
    logic          w_match;
    logic          w_hz;
    logic          w_br_ok;
    logic          w_stall_fd;
    logic          w_stall_ex;
    logic          w_bubble_ex;
    logic          w_redirect;
    logic [1:0]    w_state_nxt;
    logic [BW-1:0] w_busy_nxt;

    assign w_live_dec = dec_valid & (dec_epoch == r_epoch);
    assign w_match    = (dec_src_used[0] & (dec_rn == ex_rd))
                      | (dec_src_used[1] & (dec_rm == ex_rd))
                      | (dec_src_used[2] & (dec_rs == ex_rd));
    assign w_hz       = w_live_dec & ex_valid & ex_is_load
                      & (ex_rd != 4'd15) & w_match;
    assign w_br_ok    = br_taken & (br_epoch == r_epoch);

    // Priority decode of stall/bubble/redirect and next state
    always_comb begin
        w_stall_fd  = 1'b0;
        w_stall_ex  = 1'b0;
        w_bubble_ex = 1'b0;
        w_redirect  = 1'b0;
        w_state_nxt = S_RUN;
        if (rst) begin
            w_state_nxt = S_RUN;
        end else if (mem_busy) begin
            w_stall_fd  = 1'b1;
            w_stall_ex  = 1'b1;
            w_state_nxt = S_MEM;
        end else if (w_br_ok) begin
            w_redirect  = 1'b1;
            w_state_nxt = S_FLUSH;
        end else if (w_hz) begin
            w_stall_fd  = 1'b1;
            w_bubble_ex = 1'b1;
            w_state_nxt = S_LU;
        end
    end

    assign w_busy_nxt = (r_busy_cnt == BW'(MEM_TIMEOUT))
                      ? r_busy_cnt : r_busy_cnt + BW'(1);

    // Epoch toggle and informational state
    always_ff @(posedge clk) begin
        if (rst) begin
            r_epoch <= 1'b0;
            r_state <= S_RUN;
        end else begin
            r_state <= w_state_nxt;
            if (w_redirect) begin
                r_epoch <= ~r_epoch;
            end
        end
    end

    // Saturating stall-cycle counter; clear beats increment
    always_ff @(posedge clk) begin
        if (rst || perf_clear) begin
            r_stall_cnt <= '0;
        end else if (w_stall_fd && (r_stall_cnt != '1)) begin
            r_stall_cnt <= r_stall_cnt + CNT_W'(1);
        end
    end

    // Memory-busy watchdog with sticky timeout flag
    always_ff @(posedge clk) begin
        if (rst) begin
            r_busy_cnt <= '0;
            r_timeout  <= 1'b0;
        end else if (mem_busy) begin
            r_busy_cnt <= w_busy_nxt;
            if (w_busy_nxt == BW'(MEM_TIMEOUT)) begin
                r_timeout <= 1'b1;
            end
        end else begin
            r_busy_cnt <= '0;
        end
    end

    assign stall_fd    = w_stall_fd;
    assign stall_ex    = w_stall_ex;
    assign bubble_ex   = w_bubble_ex;
    assign redirect    = w_redirect;
    assign epoch       = r_epoch;
    assign state       = r_state;
    assign stall_cnt   = r_stall_cnt;
    assign mem_timeout = r_timeout;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed self-checking bench for pipeline_hazard_ctrl.
// Uses MEM_TIMEOUT=4 and CNT_W=4 to reach the boundaries quickly.
module tb_pipeline_hazard_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       dec_valid, dec_epoch;
    logic [3:0] dec_rn, dec_rm, dec_rs;
    logic [2:0] dec_src_used;
    logic       ex_valid, ex_is_load;
    logic [3:0] ex_rd;
    logic       br_taken, br_epoch, mem_busy, perf_clear;
    logic       stall_fd, stall_ex, bubble_ex, redirect, epoch;
    logic [1:0] state;
    logic [3:0] stall_cnt;
    logic       mem_timeout;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    pipeline_hazard_ctrl #(.MEM_TIMEOUT(4), .CNT_W(4)) dut (
        .clk(clk), .rst(rst),
        .dec_valid(dec_valid), .dec_epoch(dec_epoch),
        .dec_rn(dec_rn), .dec_rm(dec_rm), .dec_rs(dec_rs),
        .dec_src_used(dec_src_used),
        .ex_valid(ex_valid), .ex_is_load(ex_is_load), .ex_rd(ex_rd),
        .br_taken(br_taken), .br_epoch(br_epoch),
        .mem_busy(mem_busy), .perf_clear(perf_clear),
        .stall_fd(stall_fd), .stall_ex(stall_ex),
        .bubble_ex(bubble_ex), .redirect(redirect),
        .epoch(epoch), .state(state),
        .stall_cnt(stall_cnt), .mem_timeout(mem_timeout)
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic idle();
        rst = 0; dec_valid = 0; dec_epoch = 0;
        dec_rn = 0; dec_rm = 0; dec_rs = 0; dec_src_used = 0;
        ex_valid = 0; ex_is_load = 0; ex_rd = 0;
        br_taken = 0; br_epoch = 0; mem_busy = 0; perf_clear = 0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic hazard(input logic ep);
        ex_valid = 1; ex_is_load = 1; ex_rd = 4'd3;
        dec_valid = 1; dec_epoch = ep; dec_rm = 4'd3; dec_src_used = 3'b010;
    endtask

    initial begin
        idle();
        // reset with active causes: outputs held low
        rst = 1; mem_busy = 1; br_taken = 1;
        #1;
        chk("rst_stall_fd", 32'(stall_fd), 0);
        chk("rst_stall_ex", 32'(stall_ex), 0);
        chk("rst_redirect", 32'(redirect), 0);
        chk("rst_bubble", 32'(bubble_ex), 0);
        tick(); tick();
        idle();
        #1;
        chk("rst_epoch", 32'(epoch), 0);
        chk("rst_state", 32'(state), 0);
        chk("rst_cnt", 32'(stall_cnt), 0);
        chk("rst_tmo", 32'(mem_timeout), 0);

        // load-use hazard
        hazard(1'b0);
        #1;
        chk("lu_stall_fd", 32'(stall_fd), 1);
        chk("lu_bubble", 32'(bubble_ex), 1);
        chk("lu_stall_ex", 32'(stall_ex), 0);
        chk("lu_redirect", 32'(redirect), 0);
        tick();
        chk("lu_state", 32'(state), 1);
        chk("lu_cnt", 32'(stall_cnt), 1);
        ex_rd = 4'd15; dec_rm = 4'd15;
        #1;
        chk("lu_r15", 32'(stall_fd), 0);
        tick();
        chk("lu_r15_state", 32'(state), 0);
        ex_rd = 4'd3; dec_rm = 4'd3; dec_src_used = 3'b000;
        #1;
        chk("lu_unused", 32'(stall_fd), 0);
        dec_src_used = 3'b010; dec_epoch = 1'b1;
        #1;
        chk("lu_stale_dec", 32'(stall_fd), 0);
        tick();
        idle();

        // taken branch, then stale branch
        br_taken = 1; br_epoch = 0;
        #1;
        chk("br_redirect", 32'(redirect), 1);
        chk("br_stall", 32'(stall_fd), 0);
        tick();
        chk("br_epoch", 32'(epoch), 1);
        chk("br_state", 32'(state), 3);
        #1;
        chk("br_stale", 32'(redirect), 0);
        tick();
        chk("br_stale_epoch", 32'(epoch), 1);
        chk("br_stale_state", 32'(state), 0);
        // branch beats same-cycle load-use
        hazard(1'b1);
        br_taken = 1; br_epoch = 1;
        #1;
        chk("brhz_redirect", 32'(redirect), 1);
        chk("brhz_stall", 32'(stall_fd), 0);
        chk("brhz_bubble", 32'(bubble_ex), 0);
        tick();
        chk("brhz_epoch", 32'(epoch), 0);
        chk("brhz_cnt", 32'(stall_cnt), 1);
        idle();

        // clear perf counter
        perf_clear = 1;
        tick();
        perf_clear = 0;
        chk("clr_cnt", 32'(stall_cnt), 0);

        // memory stall with pending branch; watchdog at 4
        mem_busy = 1; br_taken = 1; br_epoch = 0;
        for (int i = 0; i < 5; i++) begin
            #1;
            chk("mem_stall_fd", 32'(stall_fd), 1);
            chk("mem_stall_ex", 32'(stall_ex), 1);
            chk("mem_redirect", 32'(redirect), 0);
            tick();
            chk("mem_epoch", 32'(epoch), 0);
            chk("mem_tmo", 32'(mem_timeout), (i >= 3) ? 1 : 0);
        end
        chk("mem_state", 32'(state), 2);
        chk("mem_cnt", 32'(stall_cnt), 5);
        mem_busy = 0;
        #1;
        chk("mem_release_redirect", 32'(redirect), 1);
        tick();
        br_taken = 0;
        chk("mem_release_epoch", 32'(epoch), 1);
        chk("tmo_sticky", 32'(mem_timeout), 1);
        tick();
        chk("tmo_sticky2", 32'(mem_timeout), 1);

        // reset mid-operation drops pending redirect
        rst = 1; br_taken = 1; br_epoch = 1;
        #1;
        chk("rst_mid_redirect", 32'(redirect), 0);
        tick();
        idle();
        #1;
        chk("rst_mid_epoch", 32'(epoch), 0);
        chk("rst_mid_tmo", 32'(mem_timeout), 0);
        chk("rst_mid_cnt", 32'(stall_cnt), 0);

        // counter saturation then clear with simultaneous stall
        hazard(1'b0);
        for (int i = 0; i < 20; i++) tick();
        chk("sat_cnt", 32'(stall_cnt), 15);
        perf_clear = 1;
        #1;
        chk("clr_stall_fd", 32'(stall_fd), 1);
        tick();
        chk("clr_wins", 32'(stall_cnt), 0);
        perf_clear = 0;
        tick();
        chk("cnt_after_clr", 32'(stall_cnt), 1);
        idle();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
